// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte-wide S-box lookups.
// sbox() only feeds the optional result self-check.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Indexed by {row, col} = {high nibble, low nibble}
    localparam logic [7:0] INV_SBOX_TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Block-in / block-out valid-ready bus of the InvSubBytes engine.
// slave = engine side, master = producer/consumer side.
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/inv_sbox_byte.sv
// Single-byte combinational inverse S-box lookup.
module inv_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    assign data_o = inv_sbox(data_i);

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: LANES bytes per cycle, byte 0 first.
// Define INV_SUB_BYTES_SELFCHECK_EN to re-encrypt each result and raise a sticky err on mismatch.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    inv_sub_bytes_seq_if.slave bus,
    output logic               busy,
    output logic               err
);

    localparam int unsigned NCYC    = AES_NBYTES / LANES;
    localparam int unsigned CNT_W   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int unsigned LANE_W  = 8 * LANES;
    localparam int unsigned LANE_SH = $clog2(LANE_W);
    localparam int unsigned IDX_W   = $clog2(AES_BLOCK_W);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] work_q, work_d;
    logic [LANE_W-1:0]      lane_in, lane_out;
    logic [IDX_W-1:0]       lane_base;
    logic                   in_ready, out_valid, last_cyc, accept;

    assign lane_base = IDX_W'(cnt_q) << LANE_SH;
    assign lane_in   = work_q[lane_base +: LANE_W];
    assign last_cyc  = (cnt_q == CNT_W'(NCYC - 1));
    assign accept    = in_ready & bus.in_valid;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox_byte u_inv_sbox (
            .data_i (lane_in[8*l +: 8]),
            .data_o (lane_out[8*l +: 8])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    work_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d[lane_base +: LANE_W] = lane_out;
                if (last_cyc) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    // Work register is only written in IDLE/RUN, so it is frozen while out_valid is high
    assign bus.out_data  = work_q;
    assign busy          = (state_q != StIdle);

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    logic [AES_BLOCK_W-1:0] copy_q, copy_d;
    logic                   err_q, err_d, mismatch;

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < AES_NBYTES; i++) begin
            if (sbox(work_q[8*i +: 8]) != copy_q[8*i +: 8]) begin
                mismatch = 1'b1;
            end
        end
        copy_d = accept ? bus.in_data : copy_q;
        err_d  = err_q | (out_valid & bus.out_ready & mismatch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            copy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            copy_q <= copy_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: main LANES=4 instance plus streaming instances for
// every legal LANES, checked against an algebraic (GF(2^8) inverse + affine) S-box model.
module tb_inv_sub_bytes_seq;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    logic busy, err;
    logic s_busy [5];
    logic s_err  [5];
    bit   s_done [5];
    int   num_checks = 0;
    int   num_errs   = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_seq_if m_if ();

    inv_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (m_if.slave),
        .busy (busy),
        .err  (err)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) r = r ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return r;
    endfunction

    // Forward S-box from first principles: x^254 then the affine map
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int k = 0; k < 254; k++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accept edge, with in_data scrambled
    task automatic send_m(input logic [127:0] d);
        int n = 0;
        m_if.in_valid = 1'b1;
        m_if.in_data  = d;
        while (!m_if.in_ready && n < 64) begin
            step();
            n++;
        end
        step();
        m_if.in_valid = 1'b0;
        m_if.in_data  = ~d;
    endtask

    task automatic wait_m(output int n);
        n = 0;
        while (!m_if.out_valid && n < 64) begin
            step();
            n++;
        end
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int unsigned L  = 1 << g;
        localparam int unsigned NC = 16 / L;

        inv_sub_bytes_seq_if s_if ();

        inv_sub_bytes_seq #(.LANES(L)) u_dut_s (
            .clk  (clk),
            .rst  (rst_s),
            .bus  (s_if.slave),
            .busy (s_busy[g]),
            .err  (s_err[g])
        );

        initial begin
            logic [127:0] d, e;
            int n;
            s_if.in_valid  = 1'b0;
            s_if.in_data   = '0;
            s_if.out_ready = 1'b1;
            wait (rst_s == 1'b0);
            step();
            for (int b = 0; b < 16; b++) begin
                for (int i = 0; i < 16; i++) begin
                    e[8*i +: 8] = 8'(b * 16 + i);
                    d[8*i +: 8] = sbox_model(e[8*i +: 8]);
                end
                s_if.in_valid = 1'b1;
                s_if.in_data  = d;
                n = 0;
                while (!s_if.in_ready && n < 64) begin
                    step();
                    n++;
                end
                step();
                s_if.in_valid = 1'b0;
                s_if.in_data  = ~d;
                n = 0;
                while (!s_if.out_valid && n < 64) begin
                    step();
                    n++;
                end
                check_val($sformatf("L%0d_lat_b%0d", L, b), 128'(n), 128'(NC));
                check_val($sformatf("L%0d_data_b%0d", L, b), s_if.out_data, e);
                step();
            end
            check_val($sformatf("L%0d_err", L), 128'(s_err[g]), 128'(0));
            s_done[g] = 1'b1;
        end
    end

    function automatic bit all_done();
        bit r = 1'b1;
        for (int i = 0; i < 5; i++) r &= s_done[i];
        return r;
    endfunction

    initial begin
        int   n;
        logic flip;
        m_if.in_valid  = 1'b0;
        m_if.in_data   = '0;
        m_if.out_ready = 1'b1;
        repeat (3) step();
        check_val("rst_out_valid", 128'(m_if.out_valid), 128'(0));
        check_val("rst_out_data", m_if.out_data, 128'h0);
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_err", 128'(err), 128'(0));
        rst   = 1'b0;
        rst_s = 1'b0;
        step();
        check_val("idle_in_ready", 128'(m_if.in_ready), 128'(1));

        // T1
        send_m({16{8'h63}});
        check_val("t1_busy", 128'(busy), 128'(1));
        check_val("t1_in_ready_run", 128'(m_if.in_ready), 128'(0));
        wait_m(n);
        check_val("t1_latency", 128'(n), 128'(4));
        check_val("t1_data", m_if.out_data, 128'h0);
        check_val("t1_err", 128'(err), 128'(0));
        step();
        check_val("t1_in_ready_after", 128'(m_if.in_ready), 128'(1));
        check_val("t1_out_valid_after", 128'(m_if.out_valid), 128'(0));

        // T2
        send_m(128'h0000_0000_0000_0000_0000_0000_0000_7c63);
        wait_m(n);
        check_val("t2_latency", 128'(n), 128'(4));
        check_val("t2_data", m_if.out_data, 128'h52525252_52525252_52525252_52520100);
        step();

        // T3: stalled consumer, with a competing in_valid that must be ignored
        m_if.out_ready = 1'b0;
        send_m({16{8'h16}});
        wait_m(n);
        check_val("t3_latency", 128'(n), 128'(4));
        m_if.in_valid = 1'b1;
        m_if.in_data  = {16{8'h00}};
        for (int k = 0; k < 10; k++) begin
            check_val($sformatf("t3_valid_%0d", k), 128'(m_if.out_valid), 128'(1));
            check_val($sformatf("t3_data_%0d", k), m_if.out_data, {16{8'hff}});
            check_val($sformatf("t3_in_ready_%0d", k), 128'(m_if.in_ready), 128'(0));
            step();
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        step();
        check_val("t3_out_valid_rel", 128'(m_if.out_valid), 128'(0));
        check_val("t3_in_ready_rel", 128'(m_if.in_ready), 128'(1));
        step();
        check_val("t3_no_dup_busy", 128'(busy), 128'(0));

        // T4: reset on the second RUN cycle
        send_m({16{8'h63}});
        step();
        rst = 1'b1;
        #1;
        check_val("t4_rst_out_valid", 128'(m_if.out_valid), 128'(0));
        check_val("t4_rst_out_data", m_if.out_data, 128'h0);
        check_val("t4_rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        check_val("t4_no_stale_valid", 128'(m_if.out_valid), 128'(0));
        send_m({16{8'hed}});
        wait_m(n);
        check_val("t4_latency", 128'(n), 128'(4));
        check_val("t4_data", m_if.out_data, {16{8'h53}});
        step();

`ifdef INV_SUB_BYTES_SELFCHECK_EN
        // T6: corrupt byte 15 before it is substituted
        send_m({16{8'h63}});
        flip = u_dut.work_q[120];
        force u_dut.work_q[120] = ~flip;
        step();
        release u_dut.work_q[120];
        wait_m(n);
        check_val("t6_err_before_hs", 128'(err), 128'(0));
        step();
        check_val("t6_err_set", 128'(err), 128'(1));
        send_m({16{8'h63}});
        wait_m(n);
        step();
        check_val("t6_err_held", 128'(err), 128'(1));
        rst = 1'b1;
        #1;
        check_val("t6_err_cleared", 128'(err), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        step();
`else
        check_val("t6_err_tied", 128'(err), 128'(0));
`endif

        n = 0;
        while (!all_done() && n < 4000) begin
            step();
            n++;
        end
        check_val("stream_done", 128'(all_done()), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errs);
        $finish;
    end

endmodule
